// File: rtl/riscv_pkg.sv
// Shared types and constants for the trap/return sequencer.
package riscv_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_FLUSH,
    TRAP_COMMIT,
    TRAP_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_ECALL,
    KIND_IRQ,
    KIND_MRET
  } trap_kind_e;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
  // Vectored interrupts land at base + 4 * cause code (machine timer is code 7).
  localparam int unsigned MTI_VECTOR_OFFSET = 4 * 7;

  function automatic logic kind_is_trap(input logic [1:0] kind);
    return kind != KIND_MRET;
  endfunction

endpackage

// File: rtl/ysyx_22040632_trap_target.sv
// Combinational redirect target: trap vector (direct or vectored) or mepc for mret.
module ysyx_22040632_trap_target
  import riscv_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      kind,
  input  logic [PC_W-1:0] mtvec,
  input  logic [PC_W-1:0] mepc,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] base;

  // Synchronous exceptions always use the base, even in vectored mode.
  always_comb begin
    base   = {mtvec[PC_W-1:2], 2'b00};
    target = base;
    if (kind == KIND_MRET) begin
      target = mepc;
    end else if (kind == KIND_IRQ && mtvec[1:0] == MTVEC_MODE_VECTORED) begin
      target = base + PC_W'(MTI_VECTOR_OFFSET);
    end
  end

endmodule

// File: rtl/ysyx_22040632_trap_ctrl.sv
// Trap/return sequencer: detect at WB, drain pipeline, pulse CSR strobes, redirect fetch.
// Optional perf counters when YSYX_22040632_TRAP_PERF_EN is defined.
module ysyx_22040632_trap_ctrl
  import riscv_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rrst,
  input  logic            wb_valid_i,
  input  logic [PC_W-1:0] wb_pc_i,
  input  logic [PC_W-1:0] wb_npc_i,
  input  logic            wb_ecall_i,
  input  logic            wb_mret_i,
  input  logic            mtip_i,
  input  logic            mstatus_mie_bit_i,
  input  logic            mie_mtie_bit_i,
  input  logic [PC_W-1:0] mtvec_i,
  input  logic [PC_W-1:0] mepc_i,
  output logic            trap_busy_o,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  output logic            wen_ecall2csr_o,
  output logic [XLEN-1:0] NO2csr_o,
  output logic [PC_W-1:0] pc2csr_o,
  output logic            wen_mstatus_ecall2csr_o,
  output logic            wen_mstatus_mret2csr_o,
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
`ifdef YSYX_22040632_TRAP_PERF_EN
  ,
  output logic [31:0]     perf_trap_cnt_o,
  output logic [31:0]     perf_irq_cnt_o
`endif
);

  trap_state_e     state;
  trap_kind_e      kind;
  logic [PC_W-1:0] cap_pc;
  logic [XLEN-1:0] cap_cause;

  logic            irq_pending;
  logic            take_event;
  trap_kind_e      event_kind;
  logic [PC_W-1:0] event_pc;
  logic [XLEN-1:0] event_cause;
  logic [PC_W-1:0] target;

  // Priority irq > ecall > mret; an interrupt lets the retiring instruction complete.
  always_comb begin
    irq_pending = mtip_i & mstatus_mie_bit_i & mie_mtie_bit_i;
    take_event  = wb_valid_i & (irq_pending | wb_ecall_i | wb_mret_i);
    event_kind  = KIND_MRET;
    event_pc    = '0;
    event_cause = '0;
    if (irq_pending) begin
      event_kind  = KIND_IRQ;
      event_pc    = wb_npc_i;
      event_cause = XLEN'(CAUSE_MTI);
    end else if (wb_ecall_i) begin
      event_kind  = KIND_ECALL;
      event_pc    = wb_pc_i;
      event_cause = XLEN'(CAUSE_ECALL_M);
    end
  end

  ysyx_22040632_trap_target #(
    .PC_W(PC_W)
  ) u_target (
    .kind  (kind),
    .mtvec (mtvec_i),
    .mepc  (mepc_i),
    .target(target)
  );

  always_ff @(posedge clk) begin
    if (rrst) begin
      state                   <= TRAP_IDLE;
      kind                    <= KIND_ECALL;
      cap_pc                  <= '0;
      cap_cause               <= '0;
      trap_busy_o             <= 1'b0;
      flush_req_o             <= 1'b0;
      wen_ecall2csr_o         <= 1'b0;
      NO2csr_o                <= '0;
      pc2csr_o                <= '0;
      wen_mstatus_ecall2csr_o <= 1'b0;
      wen_mstatus_mret2csr_o  <= 1'b0;
      redirect_valid_o        <= 1'b0;
      redirect_pc_o           <= '0;
    end else begin
      wen_ecall2csr_o         <= 1'b0;
      NO2csr_o                <= '0;
      pc2csr_o                <= '0;
      wen_mstatus_ecall2csr_o <= 1'b0;
      wen_mstatus_mret2csr_o  <= 1'b0;
      unique case (state)
        TRAP_IDLE: begin
          if (take_event) begin
            state       <= TRAP_FLUSH;
            kind        <= event_kind;
            trap_busy_o <= 1'b1;
            flush_req_o <= 1'b1;
            if (event_kind != KIND_MRET) begin
              cap_pc    <= event_pc;
              cap_cause <= event_cause;
            end
          end
        end
        TRAP_FLUSH: begin
          if (flush_ack_i) begin
            state       <= TRAP_COMMIT;
            flush_req_o <= 1'b0;
            if (kind_is_trap(kind)) begin
              wen_ecall2csr_o         <= 1'b1;
              wen_mstatus_ecall2csr_o <= 1'b1;
              NO2csr_o                <= cap_cause;
              pc2csr_o                <= cap_pc;
            end else begin
              wen_mstatus_mret2csr_o  <= 1'b1;
            end
          end
        end
        // Target is registered here so mret sees the mepc present during COMMIT.
        TRAP_COMMIT: begin
          state            <= TRAP_REDIRECT;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= target;
        end
        TRAP_REDIRECT: begin
          if (redirect_ready_i) begin
            state            <= TRAP_IDLE;
            redirect_valid_o <= 1'b0;
            trap_busy_o      <= 1'b0;
          end
        end
        default: begin
          state <= TRAP_IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_22040632_TRAP_PERF_EN
  // Saturating event counters, bumped once per trap COMMIT.
  always_ff @(posedge clk) begin
    if (rrst) begin
      perf_trap_cnt_o <= '0;
      perf_irq_cnt_o  <= '0;
    end else if (state == TRAP_COMMIT && kind_is_trap(kind)) begin
      if (perf_trap_cnt_o != 32'hFFFF_FFFF) perf_trap_cnt_o <= perf_trap_cnt_o + 32'd1;
      if (kind == KIND_IRQ && perf_irq_cnt_o != 32'hFFFF_FFFF) begin
        perf_irq_cnt_o <= perf_irq_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
